// File: rtl/hier_pack.sv
// Packs qualified single-bit results LSB-first into words, buffers them in a
// small FIFO and hands them out on valid/ready, with ones/drop statistics.
module hier_pack #(
  parameter int WORD_W = 8,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  input  logic                         in_bit,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [WORD_W-1:0]            out_data,
  output logic [$clog2(WORD_W+1)-1:0]  out_len,
  output logic [CNT_W-1:0]             ones_cnt,
  output logic [CNT_W-1:0]             drop_cnt,
  output logic                         overflow
);

  localparam int LW = $clog2(WORD_W+1);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {EMPTY, FILL} state_t;

  state_t            state;
  logic [LW-1:0]     bcnt;
  logic [WORD_W-1:0] shreg;

  logic [WORD_W-1:0] ins_word;
  logic [LW-1:0]     ins_cnt;
  logic              word_done;
  logic              push;

  // The incoming bit is merged before the push decision, so a flush that
  // coincides with the completing bit yields a single full-length word.
  always_comb begin
    ins_word  = shreg | (WORD_W'(in_valid & in_bit) << bcnt);
    ins_cnt   = bcnt + LW'(in_valid);
    word_done = (ins_cnt == LW'(WORD_W));
    push      = word_done | (flush & (ins_cnt != '0));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= EMPTY;
      bcnt  <= '0;
      shreg <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            bcnt  <= '0;
            shreg <= '0;
          end else if (in_valid) begin
            bcnt  <= ins_cnt;
            shreg <= ins_word;
            state <= FILL;
          end
        end
        FILL: begin
          if (push) begin
            bcnt  <= '0;
            shreg <= '0;
            state <= EMPTY;
          end else begin
            bcnt  <= ins_cnt;
            shreg <= ins_word;
          end
        end
        default: begin
          bcnt  <= '0;
          shreg <= '0;
          state <= EMPTY;
        end
      endcase
    end
  end

  logic [WORD_W-1:0] data_mem [DEPTH];
  logic [LW-1:0]     len_mem  [DEPTH];
  logic [AW:0]       wptr, rptr;
  logic              fifo_empty, fifo_full, pop, push_ok;

  always_comb begin
    fifo_empty = (wptr == rptr);
    fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    pop        = !fifo_empty && out_ready;
    push_ok    = push && (!fifo_full || pop);
  end

  assign out_valid = !fifo_empty;
  assign out_data  = data_mem[rptr[AW-1:0]];
  assign out_len   = len_mem[rptr[AW-1:0]];

  // When full with a simultaneous pop, the write slot is the one being
  // vacated, so writing and advancing both pointers is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        data_mem[i] <= '0;
        len_mem[i]  <= '0;
      end
    end else begin
      if (pop) rptr <= rptr + 1'b1;
      if (push_ok) begin
        data_mem[wptr[AW-1:0]] <= ins_word;
        len_mem[wptr[AW-1:0]]  <= ins_cnt;
        wptr                   <= wptr + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ones_cnt <= '0;
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else begin
      if (in_valid && in_bit && ones_cnt != '1) ones_cnt <= ones_cnt + CNT_W'(1);
      if (push && !push_ok) begin
        overflow <= 1'b1;
        if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
      end
    end
  end

endmodule
